// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-master arbiter and sequencer in front of ram_interface. Master D is the
// load/store unit and master I is instruction fetch. Both share one
// single-port data RAM.
// One request is granted per cycle. Grants are combinational and appear in
// the same cycle as the request. D normally wins. I is forced through once it
// has been denied MAX_WAIT consecutive cycles.
// Every grant, including a misaligned one, is tracked by a response pipeline.
// Each grant returns exactly one registered rvalid pulse to its owner,
// LATENCY cycles after the grant.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata/d_type/d_sign
//                             master D request fields
//   d_gnt                     D accepted this cycle (combinational)
//   d_rvalid/d_rdata/d_err    D response (registered)
//   i_req/i_addr              master I read request (always a word, unsigned)
//   i_gnt/i_rvalid/i_rdata/i_err
//                             same meaning as the D side
//   mem_addr/mem_wdata/mem_type/mem_sign/rmem/wmem
//                             request side towards ram_interface
//   mem_rdata                 aligned/extended read data from ram_interface

`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef MemTypeBus
`define MemTypeBus 1:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef LS_B
`define LS_B 2'b00
`endif
`ifndef LS_H
`define LS_H 2'b01
`endif
`ifndef LS_W
`define LS_W 2'b10
`endif

module ram_arbiter #(
   parameter int LATENCY  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [`RegBus]       d_addr,
   input  logic [`RegBus]       d_wdata,
   input  logic [`MemTypeBus]   d_type,
   input  logic                 d_sign,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [`RegBus]       d_rdata,
   output logic                 d_err,
   input  logic                 i_req,
   input  logic [`RegBus]       i_addr,
   output logic                 i_gnt,
   output logic                 i_rvalid,
   output logic [`RegBus]       i_rdata,
   output logic                 i_err,
   output logic [`RegBus]       mem_addr,
   output logic [`RegBus]       mem_wdata,
   output logic [`MemTypeBus]   mem_type,
   output logic                 mem_sign,
   output logic                 rmem,
   output logic                 wmem,
   input  logic [`RegBus]       mem_rdata
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   // owner: 0 = master D, 1 = master I
   typedef struct packed {
      logic valid;
      logic owner;
      logic is_read;
      logic err;
   } entry_t;

   // Size/offset legality. Unknown type codes are treated as misaligned so
   // they never reach the RAM.
   function automatic logic addr_aligned(input logic [`MemTypeBus] typ,
                                         input logic [1:0]           lsb);
      logic ok;
      case (typ)
         `LS_B:   ok = 1'b1;
         `LS_H:   ok = ~lsb[0];
         `LS_W:   ok = (lsb == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   logic [3:0]     starve_cnt_r;
   logic           any_gnt_s;
   logic           req_we_s;
   logic           req_aligned_s;
   logic [`RegBus] resp_data_s;
   entry_t         new_entry_s;
   entry_t         exit_entry_s;

   // Grant selection: D priority, I forced once it has waited MAX_WAIT cycles.
   always_comb begin
      d_gnt = 1'b0;
      i_gnt = 1'b0;
      if (d_req && i_req) begin
         if (starve_cnt_r == MAX_WAIT_C) begin
            i_gnt = 1'b1;
         end else begin
            d_gnt = 1'b1;
         end
      end else if (d_req) begin
         d_gnt = 1'b1;
      end else if (i_req) begin
         i_gnt = 1'b1;
      end else begin
         d_gnt = 1'b0;
         i_gnt = 1'b0;
      end
   end

   assign any_gnt_s = d_gnt | i_gnt;

   // Request-side mux of the winning master's fields. Idle drives zeros.
   always_comb begin
      mem_addr      = `ZeroWord;
      mem_wdata     = `ZeroWord;
      mem_type      = 2'b00;
      mem_sign      = 1'b0;
      req_we_s      = 1'b0;
      req_aligned_s = 1'b0;
      if (d_gnt) begin
         mem_addr      = d_addr;
         mem_wdata     = d_wdata;
         mem_type      = d_type;
         mem_sign      = d_sign;
         req_we_s      = d_we;
         req_aligned_s = addr_aligned(d_type, d_addr[1:0]);
      end else if (i_gnt) begin
         mem_addr      = i_addr;
         mem_type      = `LS_W;
         req_aligned_s = addr_aligned(`LS_W, i_addr[1:0]);
      end else begin
         req_we_s      = 1'b0;
      end
   end

   // A misaligned access is granted and acknowledged but never strobes the RAM.
   assign rmem = any_gnt_s & ~req_we_s & req_aligned_s;
   assign wmem = any_gnt_s &  req_we_s & req_aligned_s;

   assign new_entry_s = {any_gnt_s, i_gnt, ~req_we_s, any_gnt_s & ~req_aligned_s};

   // Starvation counter: counts consecutive denied I cycles, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_r <= 4'd0;
      end else if (i_req && !i_gnt) begin
         if (starve_cnt_r != MAX_WAIT_C) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= 4'd0;
      end
   end

   // The response register counts as the last stage. The explicit shift
   // register therefore holds LATENCY-1 entries. With LATENCY=1 the grant
   // feeds the response register directly.
   generate
      if (LATENCY <= 1) begin : g_lat1
         assign exit_entry_s = new_entry_s;
      end else begin : g_pipe
         entry_t pipe_r [0:LATENCY-2];

         // Tracking pipeline: shifts every cycle, reset discards in-flight work.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < LATENCY - 1; k++) begin
                  pipe_r[k] <= '0;
               end
            end else begin
               pipe_r[0] <= new_entry_s;
               for (int k = 1; k < LATENCY - 1; k++) begin
                  pipe_r[k] <= pipe_r[k-1];
               end
            end
         end

         assign exit_entry_s = pipe_r[LATENCY-2];
      end
   endgenerate

   assign resp_data_s = (exit_entry_s.is_read && !exit_entry_s.err) ? mem_rdata : `ZeroWord;

   // Response registers: route the exiting entry to its owner. The other
   // master's rdata holds its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= `ZeroWord;
         i_rvalid <= 1'b0;
         i_err    <= 1'b0;
         i_rdata  <= `ZeroWord;
      end else begin
         d_rvalid <= exit_entry_s.valid & ~exit_entry_s.owner;
         d_err    <= exit_entry_s.valid & ~exit_entry_s.owner & exit_entry_s.err;
         i_rvalid <= exit_entry_s.valid &  exit_entry_s.owner;
         i_err    <= exit_entry_s.valid &  exit_entry_s.owner & exit_entry_s.err;
         if (exit_entry_s.valid && !exit_entry_s.owner) begin
            d_rdata <= resp_data_s;
         end else begin
            d_rdata <= d_rdata;
         end
         if (exit_entry_s.valid && exit_entry_s.owner) begin
            i_rdata <= resp_data_s;
         end else begin
            i_rdata <= i_rdata;
         end
      end
   end

endmodule
